// File: rtl/multi_change_detector.sv
// multi_change_detector
// Watches NUM_CH packed value channels, filters each for stability, and
// reports one accepted change at a time (channel id, old and new value),
// followed by a HOLD_CYCLES rate-limiting window.
//
// Handshake note: there is no back-pressure. A report is announced by
// change rising together with busy. ch_id/prev_value/new_value are valid
// from that cycle and hold until the next report. pending shows channels
// still waiting to be reported. busy is the FSM state made visible
// (1 = HOLD, 0 = IDLE).
module multi_change_detector #(
    parameter int NUM_CH        = 4,
    parameter int WIDTH         = 3,
    parameter int RESET_VALUE   = 5,
    parameter int STABLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int PULSE_MODE    = 0,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] the_signal,
    output logic                    change,
    output logic [CH_W-1:0]         ch_id,
    output logic [WIDTH-1:0]        prev_value,
    output logic [WIDTH-1:0]        new_value,
    output logic                    busy,
    output logic [NUM_CH-1:0]       pending
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [WIDTH-1:0]  RST_V      = RESET_VALUE[WIDTH-1:0];
    localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [WIDTH-1:0]  sig_ch [NUM_CH];
    logic [WIDTH-1:0]  cand_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [WIDTH-1:0]  acc_q  [NUM_CH];
    logic [WIDTH-1:0]  rep_q  [NUM_CH];

    logic [0:0]        state_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CH_W-1:0]   sel;

    // Unpack the flat input bus into one value per channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sig_ch[i] = the_signal[i*WIDTH +: WIDTH];
        end
    end

    // Stability filter: a value is accepted only after persisting STABLE_CYCLES samples.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset) begin
                cand_q[i] <= RST_V;
                cnt_q[i]  <= '0;
                acc_q[i]  <= RST_V;
            end else begin
                if (sig_ch[i] != cand_q[i]) begin
                    cand_q[i] <= sig_ch[i];
                    cnt_q[i]  <= CNT_W'(1);
                end else if (cnt_q[i] < STABLE_MAX) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
                if ((cnt_q[i] == STABLE_MAX) && (cand_q[i] != acc_q[i])) begin
                    acc_q[i] <= cand_q[i];
                end
            end
        end
    end

    // A channel is pending while its accepted value differs from the last one reported;
    // returning to the reported value silently withdraws the change.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pending[i] = (acc_q[i] != rep_q[i]);
        end
    end

    // Fixed-priority pick of the lowest pending channel.
    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = CH_W'(i);
            end
        end
    end

    // Report FSM: IDLE launches a report, HOLD times the rate-limiting window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_cnt   <= '0;
            change     <= 1'b0;
            busy       <= 1'b0;
            ch_id      <= '0;
            prev_value <= RST_V;
            new_value  <= RST_V;
            for (int i = 0; i < NUM_CH; i++) begin
                rep_q[i] <= RST_V;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pending) begin
                        ch_id      <= sel;
                        prev_value <= rep_q[sel];
                        new_value  <= acc_q[sel];
                        rep_q[sel] <= acc_q[sel];
                        change     <= 1'b1;
                        busy       <= 1'b1;
                        hold_cnt   <= '0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        change   <= 1'b0;
                        busy     <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        if (PULSE_MODE != 0) begin
                            change <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/multi_change_detector.md
Name: multi_change_detector

Overview:
- Multi-channel successor to the single-signal change checker; sits between state/value sources (e.g. pet status codes) and the LCD 16x2 refresh logic.
- Watches NUM_CH packed value channels and filters each for stability (glitch rejection).
- Reports one change at a time with channel ID and old/new values, then enforces a rate-limiting hold window.
- Offers level-hold or single-pulse output mode.

Parameters:
- NUM_CH, 4, number of monitored channels (>=1).
- WIDTH, 3, bits per channel value.
- RESET_VALUE, 5, per-channel value after reset; truncated to WIDTH.
- STABLE_CYCLES, 2, consecutive cycles a new value must persist before acceptance (>=1).
- HOLD_CYCLES, 25000000, length of the report window in clk cycles (>=2).
- PULSE_MODE, 0, 0 = change held for the whole window, 1 = change is a 1-cycle pulse.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low.
- the_signal  input  NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- change  output  1  report strobe/level.
- ch_id  output  max(1,$clog2(NUM_CH))  channel being reported.
- prev_value  output  WIDTH  last reported value of ch_id before this report.
- new_value  output  WIDTH  accepted value of ch_id being reported.
- busy  output  1  high while in HOLD.
- pending  output  NUM_CH  bit i = channel i has an unreported accepted change.

Behaviour:
- Reset (reset==0 at an edge):
  - Per channel: candidate, accepted and reported are set to RESET_VALUE; stability counter set to 0.
  - FSM goes to IDLE and the hold counter to 0.
  - Outputs: change=0, busy=0, ch_id=0, prev_value=new_value=RESET_VALUE, pending=0.
  - Reset mid-HOLD aborts the report immediately.
- Stability filter, per channel, every edge:
  - If input != candidate: candidate<=input, cnt<=1.
  - Else if cnt<STABLE_CYCLES: cnt<=cnt+1.
  - When cnt==STABLE_CYCLES and candidate!=accepted: accepted<=candidate.
  - Any glitch shorter than STABLE_CYCLES cycles is never accepted.
- pending[i] is combinational: accepted[i] != reported[i].
  - Coalescing: a channel that returns to its reported value before being serviced drops out of pending and is never reported.
  - Intermediate values are skipped; only the latest accepted value is reported.
- FSM states IDLE, HOLD.
- IDLE:
  - If pending!=0, on that edge:
    - ch_id <= lowest set pending index (fixed priority, channel 0 highest).
    - prev_value <= reported[ch_id], new_value <= accepted[ch_id].
    - reported[ch_id] <= accepted[ch_id].
    - change<=1, busy<=1, hold counter<=0, state<=HOLD.
  - Otherwise stay in IDLE with outputs unchanged.
- HOLD:
  - Counter increments each cycle.
  - If PULSE_MODE=1, change<=0 on the first HOLD edge.
  - When counter==HOLD_CYCLES-1: change<=0, busy<=0, state<=IDLE.
  - Result: busy is high exactly HOLD_CYCLES cycles, and change is high HOLD_CYCLES cycles (mode 0) or 1 cycle (mode 1).
  - Filters keep running during HOLD; pending may grow.
  - A channel accepting a further value while being reported becomes pending again; prev_value for that next report is the value just reported.
- Report spacing: at least one IDLE cycle between reports, so back-to-back reports are HOLD_CYCLES+1 cycles apart.
- Latency: input step to change high = STABLE_CYCLES+2 edges (input sampled at edge 0, accepted at edge STABLE_CYCLES, reported at edge STABLE_CYCLES+1, visible after it).
- ch_id, prev_value and new_value hold their values until the next report.
- Counters: sized $clog2(STABLE_CYCLES+1) and $clog2(HOLD_CYCLES); no wrap is possible.

Test Plan:
Bench parameters: NUM_CH=4, WIDTH=3, RESET_VALUE=5, STABLE_CYCLES=3, HOLD_CYCLES=8, PULSE_MODE=0 unless noted.
- Reset: hold reset=0 for 2 cycles with the_signal all 5, then release and wait 20 cycles -> change=0, busy=0, pending=0, prev_value=new_value=5 throughout.
- Single change: ch2 steps 5->3 and holds -> change rises 5 edges after the step, stays high 8 cycles; ch_id=2, prev=5, new=3; busy falls with change.
- Glitch: ch1 set to 7 for 2 cycles, then back to 5 -> no report, pending stays 0.
- Simultaneous: ch3->1 and ch0->6 on the same edge:
  - First report ch0 (prev 5, new 6).
  - After 1 IDLE cycle, report ch3 (prev 5, new 1), starting 9 cycles after the first report.
- Coalesce and re-report:
  - During ch0's HOLD, ch3 goes 5->2->5 (each value stable 4 cycles) -> ch3 is not reported.
  - ch0 changes 6->4 during its own HOLD -> next report is ch0 with prev 6, new 4.
- PULSE_MODE=1 plus mid-HOLD reset:
  - Single change -> change high exactly 1 cycle, busy high 8.
  - Assert reset at HOLD cycle 4 -> busy=0 and ch_id=0 on the next edge, with no further report.
